// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: default width,
// FSM encoding and iteration counter sizing.
package seq_multiplier_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the EX-stage controller (master) and the
// sequential multiplier (slave).
interface seq_multiplier_if
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic               Start;
  logic               Signed;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               Busy;
  logic               Done;
  logic [2*WIDTH-1:0] Result;

  modport master (
    output Start, Signed, A, B,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Signed, A, B,
    output Busy, Done, Result
  );

endinterface

// File: rtl/seq_multiplier_twos_abs.sv
// Magnitude/sign split of one operand; the extra magnitude bit keeps the
// most negative two's-complement value exact.
module twos_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             is_signed,
  output logic [WIDTH:0]   mag,
  output logic             neg
);

  always_comb begin
    neg = is_signed & x[WIDTH-1];
    mag = neg ? ({1'b0, ~x} + 1'b1) : {1'b0, x};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: magnitudes are multiplied over WIDTH cycles
// and the sign is applied once when the product is registered.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  seq_multiplier_if.slave   mif
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH:0]       mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   result;
  logic [CW-1:0]        count;
  logic                 neg;

  logic [WIDTH:0]       a_mag, b_mag;
  logic                 a_neg, b_neg;
  logic                 load, last;

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .x         (mif.A),
    .is_signed (mif.Signed),
    .mag       (a_mag),
    .neg       (a_neg)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .x         (mif.B),
    .is_signed (mif.Signed),
    .mag       (b_mag),
    .neg       (b_neg)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        load = mif.Start;
        if (mif.Start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        last = (count == LAST);
        if (last) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        load      = mif.Start;
        state_nxt = mif.Start ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Final partial product is folded in here so Result is ready on FIN entry.
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (load) begin
      mcand  <= {{(WIDTH-1){1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      count  <= '0;
      neg    <= a_neg ^ b_neg;
    end else if (state == ST_RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
      if (last) result <= neg ? -acc_nxt : acc_nxt;
    end
  end

  assign mif.Busy   = (state == ST_RUN);
  assign mif.Done   = (state == ST_FIN);
  assign mif.Result = result;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: table of hand-computed products plus
// sequences for back-to-back issue, ignored mid-run requests and abort.
module tb_seq_multiplier;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W)) mif ();

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .mif   (mif)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] p;
    string          name;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    mif.A      = v.a;
    mif.B      = v.b;
    mif.Signed = v.sgn;
    mif.Start  = 1'b1;
  endtask

  // Called in the Start cycle T; returns in cycle T+W+1 with Done checked.
  task automatic wait_fin(input vec_t v, input logic perturb);
    for (int unsigned i = 1; i <= W; i++) begin
      step();
      mif.Start = perturb && ((i % 8) == 5);
      if (perturb) begin
        mif.A      = $urandom;
        mif.B      = $urandom;
        mif.Signed = ~mif.Signed;
      end
      chk({v.name, " busy"}, 64'(mif.Busy), 64'd1);
      chk({v.name, " done early"}, 64'(mif.Done), 64'd0);
    end
    step();
    chk({v.name, " done"}, 64'(mif.Done), 64'd1);
    chk({v.name, " busy at fin"}, 64'(mif.Busy), 64'd0);
    chk({v.name, " result"}, mif.Result, v.p);
  endtask

  task automatic run_op(input vec_t v, input logic perturb);
    issue(v);
    wait_fin(v, perturb);
    mif.Start = 1'b0;
    step();
    chk({v.name, " done drop"}, 64'(mif.Done), 64'd0);
    chk({v.name, " result hold"}, mif.Result, v.p);
  endtask

  vec_t vecs[11];
  vec_t v1, v2;
  logic saw_done;

  initial begin
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE, "u_max_x2"};
    vecs[1]  = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "s_m3_x7"};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min_sq"};
    vecs[3]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0000, "u_zero"};
    vecs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max_sq"};
    vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1_sq"};
    vecs[6]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, "s_min_x1"};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u_2p31_sq"};
    vecs[8]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "s_max_x_min"};
    vecs[9]  = '{32'h0000_0006, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFE2, "s_6_xm5"};
    vecs[10] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFEB, "u_fffd_x7"};

    mif.Start  = 1'b0;
    mif.Signed = 1'b0;
    mif.A      = '0;
    mif.B      = '0;
    rst        = 1'b1;
    repeat (3) step();
    chk("reset busy", 64'(mif.Busy), 64'd0);
    chk("reset done", 64'(mif.Done), 64'd0);
    chk("reset result", mif.Result, 64'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_op(vecs[i], 1'b0);

    // Reset held in idle with a non-zero Result on display.
    rst = 1'b1;
    repeat (3) step();
    chk("idle reset busy", 64'(mif.Busy), 64'd0);
    chk("idle reset done", 64'(mif.Done), 64'd0);
    chk("idle reset result", mif.Result, 64'd0);
    rst = 1'b0;
    step();

    // Back-to-back: new Start in the FIN cycle of the previous op.
    v1 = vecs[1];
    v2 = '{32'd5, 32'd6, 1'b0, 64'd30, "b2b_second"};
    issue(v1);
    wait_fin(v1, 1'b0);
    issue(v2);
    step();
    mif.Start = 1'b0;
    chk("b2b busy resumes", 64'(mif.Busy), 64'd1);
    chk("b2b result held in run", mif.Result, v1.p);
    for (int unsigned i = 2; i <= W; i++) begin
      step();
      chk("b2b busy", 64'(mif.Busy), 64'd1);
      chk("b2b done early", 64'(mif.Done), 64'd0);
    end
    step();
    chk("b2b done", 64'(mif.Done), 64'd1);
    chk("b2b result", mif.Result, v2.p);
    step();
    chk("b2b done drop", 64'(mif.Done), 64'd0);

    // Start pulses and operand churn during RUN are ignored.
    run_op('{32'h0001_0003, 32'h0000_0101, 1'b0, 64'h0000_0000_0101_0303, "perturbed"}, 1'b1);
    mif.Start = 1'b0;

    // Abort mid-run.
    issue(vecs[4]);
    step();
    mif.Start = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", 64'(mif.Busy), 64'd0);
    chk("abort done", 64'(mif.Done), 64'd0);
    chk("abort result", mif.Result, 64'd0);
    saw_done = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      step();
      if (mif.Done || mif.Busy) saw_done = 1'b1;
    end
    chk("abort no late done", 64'(saw_done), 64'd0);
    run_op(vecs[2], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
